// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle sequencer and the shared MIPS datapath.
// The master side is the sequencer; the slave side is the datapath that consumes the selects.
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             overflow;
    logic             mem_ready;
    logic             PCWr;
    logic             IRWr;
    logic             RegWr;
    logic             MemWr;
    logic             MemRd;
    logic             IorD;
    logic [1:0]       RegDst;
    logic             ALUSrc;
    logic [1:0]       Mem2Reg;
    logic [1:0]       NPCSel;
    logic [1:0]       EXTOp;
    logic [2:0]       ALUOp;
    logic             SetFlag;
    logic             illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, funct, zero, overflow, mem_ready,
        output PCWr, IRWr, RegWr, MemWr, MemRd, IorD, RegDst, ALUSrc, Mem2Reg,
               NPCSel, EXTOp, ALUOp, SetFlag, illegal, state, instret
    );

    modport slave (
        output opcode, funct, zero, overflow, mem_ready,
        input  PCWr, IRWr, RegWr, MemWr, MemRd, IorD, RegDst, ALUSrc, Mem2Reg,
               NPCSel, EXTOp, ALUOp, SetFlag, illegal, state, instret
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencer stepping the shared datapath through IF/ID/EX/MEM/WB.
// Controls are decoded from the latched IR every cycle; retired instructions are counted.
module multicycle_controller #(
    parameter int CNT_W        = 32,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_controller_if.master bus
);
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_ADDU  = 4'd0,
        C_SUBU  = 4'd1,
        C_SLT   = 4'd2,
        C_JR    = 4'd3,
        C_J     = 4'd4,
        C_JAL   = 4'd5,
        C_BEQ   = 4'd6,
        C_ADDI  = 4'd7,
        C_ADDIU = 4'd8,
        C_ORI   = 4'd9,
        C_LUI   = 4'd10,
        C_LW    = 4'd11,
        C_SW    = 4'd12,
        C_ILL   = 4'd15
    } iclass_t;

    function automatic iclass_t decode(input logic [5:0] op, input logic [5:0] fn);
        iclass_t c;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100001: c = C_ADDU;
                    6'b100011: c = C_SUBU;
                    6'b101010: c = C_SLT;
                    6'b001000: c = C_JR;
                    default:   c = C_ILL;
                endcase
            end
            6'b000010: c = C_J;
            6'b000011: c = C_JAL;
            6'b000100: c = C_BEQ;
            6'b001000: c = C_ADDI;
            6'b001001: c = C_ADDIU;
            6'b001101: c = C_ORI;
            6'b001111: c = C_LUI;
            6'b100011: c = C_LW;
            6'b101011: c = C_SW;
            default:   c = C_ILL;
        endcase
        return c;
    endfunction

    state_t           state_r;
    state_t           next_s;
    logic             ovf_r;
    logic [CNT_W-1:0] instret_r;
    iclass_t          cls_s;
    logic             retire_s;

    logic       pcwr_s, irwr_s, regwr_s, memwr_s, memrd_s, iord_s, alusrc_s;
    logic       setflag_s, illegal_s;
    logic [1:0] regdst_s, mem2reg_s, npcsel_s, extop_s;
    logic [2:0] aluop_s;

    assign cls_s = decode(bus.opcode, bus.funct);

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IF;
        end else begin
            state_r <= next_s;
        end
    end

    // Signed-overflow flag captured at the end of EX for the ADDI write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (state_r == S_EX) begin
            ovf_r <= bus.overflow;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Retired-instruction counter, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_r <= '0;
        end else if (retire_s) begin
            instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instret_r <= instret_r;
        end
    end

    // Next state and per-phase controls; rst gates every strobe combinationally.
    always_comb begin
        next_s    = state_r;
        retire_s  = 1'b0;
        pcwr_s    = 1'b0;
        irwr_s    = 1'b0;
        regwr_s   = 1'b0;
        memwr_s   = 1'b0;
        memrd_s   = 1'b0;
        iord_s    = 1'b0;
        alusrc_s  = 1'b0;
        setflag_s = 1'b0;
        illegal_s = 1'b0;
        regdst_s  = 2'b00;
        mem2reg_s = 2'b00;
        npcsel_s  = 2'b00;
        extop_s   = 2'b00;
        aluop_s   = 3'b000;
        if (rst) begin
            next_s = S_IF;
        end else begin
            case (state_r)
                S_IF: begin
                    memrd_s = 1'b1;
                    if (bus.mem_ready) begin
                        irwr_s = 1'b1;
                        pcwr_s = 1'b1;
                        next_s = S_ID;
                    end else begin
                        next_s = S_IF;
                    end
                end
                S_ID: begin
                    case (cls_s)
                        C_J: begin
                            pcwr_s   = 1'b1;
                            npcsel_s = 2'b10;
                            retire_s = 1'b1;
                            next_s   = S_IF;
                        end
                        C_JAL: begin
                            pcwr_s    = 1'b1;
                            npcsel_s  = 2'b10;
                            regwr_s   = 1'b1;
                            regdst_s  = 2'b10;
                            mem2reg_s = 2'b10;
                            retire_s  = 1'b1;
                            next_s    = S_IF;
                        end
                        C_JR: begin
                            pcwr_s   = 1'b1;
                            npcsel_s = 2'b11;
                            aluop_s  = 3'b101;
                            retire_s = 1'b1;
                            next_s   = S_IF;
                        end
                        C_ILL: begin
                            illegal_s = 1'b1;
                            next_s    = ILLEGAL_TRAP ? S_HALT : S_IF;
                        end
                        default: next_s = S_EX;
                    endcase
                end
                S_EX: begin
                    case (cls_s)
                        C_ADDU: aluop_s = 3'b000;
                        C_SUBU: aluop_s = 3'b001;
                        C_SLT:  aluop_s = 3'b100;
                        C_BEQ: begin
                            aluop_s  = 3'b001;
                            pcwr_s   = bus.zero;
                            npcsel_s = 2'b01;
                        end
                        C_ORI: begin
                            aluop_s  = 3'b011;
                            alusrc_s = 1'b1;
                            extop_s  = 2'b00;
                        end
                        C_LUI: begin
                            aluop_s  = 3'b011;
                            alusrc_s = 1'b1;
                            extop_s  = 2'b10;
                        end
                        C_ADDI, C_ADDIU, C_LW, C_SW: begin
                            aluop_s  = 3'b000;
                            alusrc_s = 1'b1;
                            extop_s  = 2'b01;
                        end
                        default: aluop_s = 3'b000;
                    endcase
                    case (cls_s)
                        C_BEQ: begin
                            retire_s = 1'b1;
                            next_s   = S_IF;
                        end
                        C_LW, C_SW: next_s = S_MEM;
                        C_ADDU, C_SUBU, C_SLT, C_ORI, C_LUI, C_ADDI, C_ADDIU: next_s = S_WB;
                        default: next_s = S_IF;
                    endcase
                end
                S_MEM: begin
                    iord_s = 1'b1;
                    if (cls_s == C_LW) begin
                        memrd_s = 1'b1;
                        next_s  = bus.mem_ready ? S_WB : S_MEM;
                    end else if (cls_s == C_SW) begin
                        memwr_s  = 1'b1;
                        retire_s = bus.mem_ready;
                        next_s   = bus.mem_ready ? S_IF : S_MEM;
                    end else begin
                        next_s = S_IF;
                    end
                end
                S_WB: begin
                    regwr_s  = 1'b1;
                    retire_s = 1'b1;
                    next_s   = S_IF;
                    case (cls_s)
                        C_LW:                 mem2reg_s = 2'b01;
                        C_ADDU, C_SUBU, C_SLT: regdst_s = 2'b01;
                        C_ADDI:               setflag_s = ovf_r;
                        default:              regdst_s  = 2'b00;
                    endcase
                end
                S_HALT: next_s = S_HALT;
                default: next_s = S_IF;
            endcase
        end
    end

    assign bus.PCWr    = pcwr_s;
    assign bus.IRWr    = irwr_s;
    assign bus.RegWr   = regwr_s;
    assign bus.MemWr   = memwr_s;
    assign bus.MemRd   = memrd_s;
    assign bus.IorD    = iord_s;
    assign bus.RegDst  = regdst_s;
    assign bus.ALUSrc  = alusrc_s;
    assign bus.Mem2Reg = mem2reg_s;
    assign bus.NPCSel  = npcsel_s;
    assign bus.EXTOp   = extop_s;
    assign bus.ALUOp   = aluop_s;
    assign bus.SetFlag = setflag_s;
    assign bus.illegal = illegal_s;
    assign bus.state   = state_r;
    assign bus.instret = instret_r;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected control vectors are queued per
// instruction and compared as the FSM walks through its phases.
module tb_multicycle_controller;
    typedef struct packed {
        logic [2:0] st;
        logic       pcwr, irwr, regwr, memwr, memrd, iord;
        logic [1:0] regdst;
        logic       alusrc;
        logic [1:0] m2r, npc, ext;
        logic [2:0] aluop;
        logic       setflag, illegal;
    } ov_t;

    typedef struct {
        ov_t   exp;
        logic  mr;
        logic  z;
        logic  ov;
        string tag;
    } ent_t;

    localparam int K_ADDU = 0, K_SUBU = 1, K_SLT = 2, K_ORI = 3, K_LUI = 4, K_ADDI = 5,
                   K_ADDIU = 6, K_LW = 7, K_SW = 8, K_BEQ = 9, K_J = 10, K_JAL = 11,
                   K_JR = 12, K_ILL = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   exp_instret = 0;
    ent_t sb[$];
    ov_t  act1, act2;

    always #5 clk = ~clk;

    multicycle_controller_if #(.CNT_W(32)) bus1 ();
    multicycle_controller_if #(.CNT_W(2))  bus2 ();

    multicycle_controller #(.CNT_W(32), .ILLEGAL_TRAP(1'b0)) dut (
        .clk(clk), .rst(rst), .bus(bus1.master)
    );
    multicycle_controller #(.CNT_W(2), .ILLEGAL_TRAP(1'b1)) dut_trap (
        .clk(clk), .rst(rst2), .bus(bus2.master)
    );

    assign act1 = {bus1.state, bus1.PCWr, bus1.IRWr, bus1.RegWr, bus1.MemWr, bus1.MemRd,
                   bus1.IorD, bus1.RegDst, bus1.ALUSrc, bus1.Mem2Reg, bus1.NPCSel,
                   bus1.EXTOp, bus1.ALUOp, bus1.SetFlag, bus1.illegal};
    assign act2 = {bus2.state, bus2.PCWr, bus2.IRWr, bus2.RegWr, bus2.MemWr, bus2.MemRd,
                   bus2.IorD, bus2.RegDst, bus2.ALUSrc, bus2.Mem2Reg, bus2.NPCSel,
                   bus2.EXTOp, bus2.ALUOp, bus2.SetFlag, bus2.illegal};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ov_t base(input logic [2:0] st);
        ov_t o;
        o    = '0;
        o.st = st;
        return o;
    endfunction

    task automatic push(input ov_t e, input logic mr, input logic z, input logic ov,
                        input string tag);
        ent_t n;
        n.exp = e; n.mr = mr; n.z = z; n.ov = ov; n.tag = tag;
        sb.push_back(n);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction; returns 1 if it retires.
    task automatic build_seq(input string nm, input int k, input logic z, input logic ov,
                             input int waits, output int ret);
        ov_t e;
        ret = 1;
        e = base(3'd0); e.memrd = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1;
        push(e, 1'b1, z, 1'b0, {nm, "_if"});
        e = base(3'd1);
        case (k)
            K_J:   begin e.pcwr = 1'b1; e.npc = 2'b10; end
            K_JAL: begin e.pcwr = 1'b1; e.npc = 2'b10; e.regwr = 1'b1;
                         e.regdst = 2'b10; e.m2r = 2'b10; end
            K_JR:  begin e.pcwr = 1'b1; e.npc = 2'b11; e.aluop = 3'b101; end
            K_ILL: begin e.illegal = 1'b1; ret = 0; end
            default: ;
        endcase
        push(e, 1'b1, z, 1'b0, {nm, "_id"});
        if (k == K_J || k == K_JAL || k == K_JR || k == K_ILL) return;
        e = base(3'd2);
        case (k)
            K_SUBU: e.aluop = 3'b001;
            K_SLT:  e.aluop = 3'b100;
            K_BEQ:  begin e.aluop = 3'b001; e.pcwr = z; e.npc = 2'b01; end
            K_ORI:  begin e.aluop = 3'b011; e.alusrc = 1'b1; e.ext = 2'b00; end
            K_LUI:  begin e.aluop = 3'b011; e.alusrc = 1'b1; e.ext = 2'b10; end
            K_ADDI, K_ADDIU, K_LW, K_SW: begin e.alusrc = 1'b1; e.ext = 2'b01; end
            default: e.aluop = 3'b000;
        endcase
        push(e, 1'b1, z, ov, {nm, "_ex"});
        if (k == K_BEQ) return;
        if (k == K_LW || k == K_SW) begin
            for (int w = 0; w <= waits; w++) begin
                e = base(3'd3); e.iord = 1'b1;
                if (k == K_LW) e.memrd = 1'b1; else e.memwr = 1'b1;
                push(e, (w == waits), z, 1'b0, {nm, "_mem"});
            end
            if (k == K_SW) return;
        end
        e = base(3'd4); e.regwr = 1'b1;
        if (k == K_LW) e.m2r = 2'b01;
        if (k == K_ADDU || k == K_SUBU || k == K_SLT) e.regdst = 2'b01;
        if (k == K_ADDI) e.setflag = ov;
        push(e, 1'b1, z, 1'b0, {nm, "_wb"});
    endtask

    // Drive one queued cycle's inputs, compare at the falling edge, advance to posedge+1.
    task automatic step();
        ent_t e;
        e = sb.pop_front();
        bus1.mem_ready = e.mr;
        bus1.zero      = e.z;
        bus1.overflow  = e.ov;
        @(negedge clk);
        check(e.tag, act1, e.exp);
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input string nm, input int k, input logic [5:0] op,
                             input logic [5:0] fn, input logic z, input logic ov,
                             input int waits);
        int ret;
        bus1.opcode = op;
        bus1.funct  = fn;
        build_seq(nm, k, z, ov, waits, ret);
        while (sb.size() > 0) step();
        exp_instret += ret;
        check({nm, "_instret"}, bus1.instret, exp_instret);
    endtask

    initial begin
        int ret;
        bus1.opcode = 6'd0; bus1.funct = 6'd0; bus1.zero = 1'b0;
        bus1.overflow = 1'b0; bus1.mem_ready = 1'b1;
        bus2.opcode = 6'b000010; bus2.funct = 6'd0; bus2.zero = 1'b0;
        bus2.overflow = 1'b0; bus2.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", act1, base(3'd0));
        check("reset_instret", bus1.instret, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_instr("addu",  K_ADDU,  6'b000000, 6'b100001, 1'b0, 1'b0, 0);
        run_instr("subu",  K_SUBU,  6'b000000, 6'b100011, 1'b0, 1'b0, 0);
        run_instr("slt",   K_SLT,   6'b000000, 6'b101010, 1'b0, 1'b0, 0);
        run_instr("ori",   K_ORI,   6'b001101, 6'b111111, 1'b0, 1'b0, 0);
        run_instr("lui",   K_LUI,   6'b001111, 6'b000000, 1'b0, 1'b0, 0);
        run_instr("addi1", K_ADDI,  6'b001000, 6'b000000, 1'b0, 1'b1, 0);
        run_instr("addi0", K_ADDI,  6'b001000, 6'b000000, 1'b0, 1'b0, 0);
        run_instr("addiu", K_ADDIU, 6'b001001, 6'b000000, 1'b0, 1'b1, 0);
        run_instr("lw3",   K_LW,    6'b100011, 6'b000000, 1'b0, 1'b0, 3);
        run_instr("lw0",   K_LW,    6'b100011, 6'b000000, 1'b0, 1'b0, 0);
        run_instr("sw2",   K_SW,    6'b101011, 6'b000000, 1'b0, 1'b0, 2);
        run_instr("beq1",  K_BEQ,   6'b000100, 6'b000000, 1'b1, 1'b0, 0);
        run_instr("beq0",  K_BEQ,   6'b000100, 6'b000000, 1'b0, 1'b0, 0);
        run_instr("j",     K_J,     6'b000010, 6'b000000, 1'b1, 1'b0, 0);
        run_instr("jal",   K_JAL,   6'b000011, 6'b000000, 1'b0, 1'b0, 0);
        run_instr("jr",    K_JR,    6'b000000, 6'b001000, 1'b0, 1'b0, 0);
        run_instr("ill",   K_ILL,   6'b111111, 6'b000000, 1'b0, 1'b0, 0);
        run_instr("illsp", K_ILL,   6'b000000, 6'b000000, 1'b0, 1'b0, 0);
        run_instr("addu2", K_ADDU,  6'b000000, 6'b100001, 1'b0, 1'b0, 0);

        // Reset while a store is stalled in MEM.
        bus1.opcode = 6'b101011;
        bus1.funct  = 6'd0;
        build_seq("swrst", K_SW, 1'b0, 1'b0, 2, ret);
        repeat (4) step();
        check("swrst_memwr_pre", bus1.MemWr, 64'd1);
        check("swrst_state_pre", bus1.state, 64'd3);
        #2 rst = 1'b1;
        #1;
        check("swrst_memwr", bus1.MemWr, 64'd0);
        check("swrst_state", bus1.state, 64'd0);
        check("swrst_instret", bus1.instret, 64'd0);
        check("swrst_memrd", bus1.MemRd, 64'd0);
        sb.delete();
        exp_instret = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr("addu3", K_ADDU, 6'b000000, 6'b100001, 1'b0, 1'b0, 0);

        // Narrow counter wrap and illegal-opcode trap on the second instance.
        rst2 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            repeat (2) @(posedge clk);
            #1;
            check("wrap_instret", bus2.instret, i % 4);
        end
        bus2.opcode = 6'b111111;
        @(negedge clk);
        check("trap_if_state", bus2.state, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        begin
            ov_t e;
            e = base(3'd1); e.illegal = 1'b1;
            check("trap_id", act2, e);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("trap_halt", act2, base(3'd7));
        end
        check("trap_instret", bus2.instret, 64'd1);
        rst2 = 1'b1;
        #1;
        check("trap_rst_state", bus2.state, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle sequencer for the MIPS core. It replaces the single-cycle combinational controller with a Moore FSM that steps the shared datapath (PC, IR, register file, one ALU, one unified memory port) through IF/ID/EX/MEM/WB phases. It decodes the latched IR opcode/funct, drives the same mux-select encodings as the single-cycle controller, and adds per-phase write enables, a memory-ready handshake and a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter
ILLEGAL_TRAP, 0, 1 = park in S_HALT on illegal opcode; 0 = skip instruction and continue

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
opcode  in  6  IR[31:26], stable after IF
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag (valid in EX)
overflow  in  1  ALU signed-overflow flag (valid in EX)
mem_ready  in  1  memory port completes access this cycle
PCWr  out  1  PC load enable
IRWr  out  1  IR load enable
RegWr  out  1  register-file write enable
MemWr  out  1  data write strobe
MemRd  out  1  memory read strobe (fetch or load)
IorD  out  1  0 = address from PC, 1 = from ALU result
RegDst  out  2  00 rt, 01 rd, 10 $31
ALUSrc  out  1  0 = rt, 1 = extended immediate
Mem2Reg  out  2  00 ALU, 01 MDR, 10 PC+4
NPCSel  out  2  00 PC+4, 01 branch, 10 jump, 11 rs (jr)
EXTOp  out  2  00 zero-ext, 01 sign-ext, 10 lui
ALUOp  out  3  000 add, 001 sub, 011 or, 100 slt, 101 pass-a
SetFlag  out  1  ADDI overflow-flag write (WB, overflow latched)
illegal  out  1  one-cycle pulse in ID on undecodable instruction
state  out  3  current state, for debug
instret  out  CNT_W  count of retired instructions

Behaviour:
- States: S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4, S_HALT=7.
- Reset (async, while rst=1): state=S_IF. All write enables (PCWr, IRWr, RegWr, MemWr, SetFlag) and MemRd, illegal forced 0. instret=0. Selects default to 0.
- S_IF: MemRd=1, IorD=0. Hold until mem_ready=1. In that cycle IRWr=1, PCWr=1, NPCSel=00, then go to S_ID.
- S_ID decode:
  - J: PCWr=1, NPCSel=10, retire, go to S_IF.
  - JAL: additionally RegWr=1, RegDst=10, Mem2Reg=10 (PC+4 already in PC), go to S_IF.
  - JR (SPECIAL/001000): PCWr=1, NPCSel=11, ALUOp=101, go to S_IF.
  - Other legal instructions go to S_EX.
  - Illegal: illegal=1, no writes, no retire; go to S_HALT if ILLEGAL_TRAP else S_IF.
- S_EX selects per instruction class:
  - ADDU: ALUOp 000, ALUSrc 0.
  - SUBU/BEQ: ALUOp 001, ALUSrc 0.
  - SLT: ALUOp 100, ALUSrc 0.
  - ORI: ALUOp 011, ALUSrc 1, EXTOp 00.
  - LUI: ALUOp 011, ALUSrc 1, EXTOp 10.
  - ADDI/ADDIU/LW/SW: ALUOp 000, ALUSrc 1, EXTOp 01.
  - The internal ovf_q register captures overflow at the end of EX.
  - BEQ: PCWr=zero, NPCSel=01, retire, go to S_IF.
  - LW/SW go to S_MEM; all others go to S_WB.
- S_MEM: IorD=1. LW: MemRd=1. SW: MemWr=1 held until mem_ready. On mem_ready, LW goes to S_WB; SW retires and goes to S_IF. Strobes stay asserted and state holds while mem_ready=0.
- S_WB: RegWr=1 and Mem2Reg as follows:
  - LW: Mem2Reg 01, RegDst 00.
  - R-type: Mem2Reg 00, RegDst 01.
  - I-type: Mem2Reg 00, RegDst 00.
  - ADDI: SetFlag=1 if ovf_q; RegWr is still 1.
  - Retire, go to S_IF.
- Cycle counts (mem_ready always 1): J/JAL/JR 2, BEQ 3, R-type/I-type/SW 4, LW 5.
- instret increments on the retire edge and wraps modulo 2^CNT_W.
- S_HALT: all enables 0, remains until rst.
- Outputs are a Moore function of state, opcode and funct, except PCWr in EX (zero) and the mem_ready-qualified IRWr/PCWr in IF.
- Reset asserted mid-instruction aborts immediately. No partial write completes after rst rises.

Test Plan:
- ADDU (000000/100001), mem_ready=1 → state 0,1,2,4,0. RegWr=1 only in WB with RegDst=01, ALUOp=000 in EX. instret 0→1.
- LW (100011) with mem_ready low 3 cycles in S_MEM → MemRd=1, IorD=1 held 4 cycles, then WB with Mem2Reg=01. Total 8 cycles. MemWr never 1.
- BEQ (000100) with zero=1 → PCWr=1, NPCSel=01 in EX. With zero=0 → PCWr=0 in EX. 3 cycles each.
- JAL (000011) → ID cycle has PCWr=1, NPCSel=10, RegWr=1, RegDst=10, Mem2Reg=10, then back to IF. ADDI (001000) with overflow=1 in EX → SetFlag=1 in WB.
- Illegal opcode 111111 with ILLEGAL_TRAP=1 → illegal pulse, state 7, no writes, instret unchanged. With ILLEGAL_TRAP=0 → returns to IF.
- rst raised during S_MEM of SW → MemWr drops the same cycle (asynchronously), state=0, instret=0. After release, fetch resumes normally.
